// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and the CPU memory
// control block that drives it.
package mem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Meaning of the RW request line.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Opcodes used by the memory control block when issuing requests.
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    // A byte address is only usable when it lands on a word boundary.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed single-port RAM with a registered read port.
// Contents are deliberately not reset.
module mem_array #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write when enabled; the read port always returns the pre-write word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Data-memory slave: accepts one load/store at a time, waits a fixed
// number of cycles, then performs the access and pulses ready for one
// cycle with an error qualifier for misaligned or out-of-range addresses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              RW,
    input  logic [ADDR_W-1:0] add_bus,
    input  logic [DATA_W-1:0] data_bus,
    output logic [DATA_W-1:0] data_reg,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q;
    logic              err_q;
    logic              rd_hit_q;
    logic [DATA_W-1:0] data_hold_q;

    logic              acc_rw;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_fire;
    logic              acc_oor;
    logic              acc_err;
    logic              acc_rd_ok;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // With zero wait states the access happens on the accepting edge, so the
    // operands come straight from the bus; otherwise from the latched copy.
    assign acc_rw    = (state_q == IDLE) ? RW       : rw_q;
    assign acc_addr  = (state_q == IDLE) ? add_bus  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? data_bus : wdata_q;

    // The edge that enters RESP is the one that performs the access.
    assign acc_fire = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == CNT_ONE));

    // Anything above the word-index bits must be zero to be in range.
    generate
        if (ADDR_W - 2 > IDX_W) begin : g_oor
            assign acc_oor = |acc_addr[ADDR_W-1:2+IDX_W];
        end else begin : g_no_oor
            assign acc_oor = 1'b0;
        end
    endgenerate

    assign acc_err   = is_misaligned(acc_addr[1:0]) || acc_oor;
    assign acc_rd_ok = acc_fire && !acc_err && (acc_rw == RW_READ);
    // Reset wins over a coinciding commit edge.
    assign ram_we    = acc_fire && !acc_err && (acc_rw == RW_WRITE) && !rst;

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (acc_addr[2 +: IDX_W]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Request FSM with wait counter, operand latches and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            rd_hit_q    <= 1'b0;
            data_hold_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        rw_q    <= RW;
                        addr_q  <= add_bus;
                        wdata_q <= data_bus;
                        cnt_q   <= CNT_LOAD;
                        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    rd_hit_q <= 1'b0;
                    // Freeze the read word so data_reg holds after RESP.
                    if (rd_hit_q) begin
                        data_hold_q <= ram_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (acc_fire) begin
                ready_q  <= 1'b1;
                err_q    <= acc_err;
                rd_hit_q <= acc_rd_ok;
                if (!acc_rd_ok) begin
                    data_hold_q <= '0;
                end
            end
        end
    end

    // During a valid read response the RAM's registered output is the data.
    assign data_reg = rd_hit_q ? ram_rdata : data_hold_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

endmodule
